prbs_gen: RTL and testbench

PRBS_GEN -- requirements
Module: prbs_gen

---
 rtl/prbs_gen.sv | 226 ++++++++++++++++++++++
 tb/tb_prbs_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_gen.sv
// prbs_gen: framed PRBS word generator.
// A run sends an optional preamble, repeated n_rep times, and then prbs_len words
// from a Fibonacci LFSR. A prbs_len of 0 means the PRBS phase runs until stop.
// The LFSR advances DATA_W single steps on every accepted word.
// Optional build: defining PRBS_GEN_ERR_INJECT_EN adds the inj_err input.
// A pulse on inj_err flips bit 0 of the next PRBS word that is accepted.
// The LFSR sequence itself is not changed by an injected error.
//
// state      | meaning
// S_IDLE     | waiting for start, out_valid low
// S_PREAMBLE | presenting preamble words, most-significant word first
// S_PRBS     | presenting lfsr[DATA_W-1:0], stepping on each transfer
module prbs_gen #(
  parameter int DATA_W     = 8,
  parameter int LFSR_W     = 16,
  parameter int PREAMBLE_W = 32
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [7:0]            n_rep,
  input  logic [15:0]           prbs_len,
  input  logic [PREAMBLE_W-1:0] preamble,
  input  logic [LFSR_W-1:0]     seed,
  input  logic [LFSR_W-1:0]     taps,
`ifdef PRBS_GEN_ERR_INJECT_EN
  input  logic                  inj_err,
`endif
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  in_preamble,
  output logic                  done
);

  localparam int NW  = PREAMBLE_W / DATA_W;
  localparam int WCW = $clog2(NW + 1);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PRBS} state_t;

  state_t                state_q, state_d;
  logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]     taps_q, taps_d;
  logic [PREAMBLE_W-1:0] pre_q, pre_d;
  logic [7:0]            rep_left_q, rep_left_d;
  logic [WCW-1:0]        word_left_q, word_left_d;
  logic [15:0]           prbs_left_q, prbs_left_d;
  logic                  endless_q, endless_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_pre_q, in_pre_d;
  logic                  done_q, done_d;

  logic                  xfer;
  logic [LFSR_W-1:0]     seed_fix;
  logic [LFSR_W-1:0]     lfsr_nxt;
  logic [PREAMBLE_W-1:0] pre_rot;

  // Advance the LFSR by DATA_W single Fibonacci steps.
  function automatic logic [LFSR_W-1:0] lfsr_adv(input logic [LFSR_W-1:0] v,
                                                  input logic [LFSR_W-1:0] t);
    logic [LFSR_W-1:0] r;
    r = v;
    for (int i = 0; i < DATA_W; i++) begin
      r = {r[LFSR_W-2:0], ^(r & t)};
    end
    return r;
  endfunction

  assign xfer     = out_valid_q && out_ready;
  assign seed_fix = (seed == '0) ? LFSR_W'(1) : seed;
  assign lfsr_nxt = lfsr_adv(lfsr_q, taps_q);
  // Rotating the captured preamble left by one word brings the next word to the top.
  // After a full pass it is back in its original order, ready for the next repetition.
  assign pre_rot  = (pre_q << DATA_W) | (pre_q >> (PREAMBLE_W - DATA_W));

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    taps_d      = taps_q;
    pre_d       = pre_q;
    rep_left_d  = rep_left_q;
    word_left_d = word_left_q;
    prbs_left_d = prbs_left_q;
    endless_d   = endless_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_pre_d    = in_pre_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pre_d       = preamble;
          taps_d      = taps;
          lfsr_d      = seed_fix;
          endless_d   = (prbs_len == 16'd0);
          prbs_left_d = prbs_len;
          rep_left_d  = n_rep;
          word_left_d = WCW'(NW);
          out_valid_d = 1'b1;
          if (n_rep != 8'd0) begin
            state_d    = S_PREAMBLE;
            in_pre_d   = 1'b1;
            out_data_d = preamble[PREAMBLE_W-1 -: DATA_W];
          end else begin
            state_d    = S_PRBS;
            in_pre_d   = 1'b0;
            out_data_d = seed_fix[DATA_W-1:0];
          end
        end
      end
      S_PREAMBLE: begin
        if (xfer) begin
          pre_d = pre_rot;
          if (word_left_q == WCW'(1)) begin
            word_left_d = WCW'(NW);
            if (rep_left_q == 8'd1) begin
              rep_left_d = 8'd0;
              state_d    = S_PRBS;
              in_pre_d   = 1'b0;
              out_data_d = lfsr_q[DATA_W-1:0];
            end else begin
              rep_left_d = rep_left_q - 8'd1;
              out_data_d = pre_rot[PREAMBLE_W-1 -: DATA_W];
            end
          end else begin
            word_left_d = word_left_q - WCW'(1);
            out_data_d  = pre_rot[PREAMBLE_W-1 -: DATA_W];
          end
        end
      end
      S_PRBS: begin
        if (xfer) begin
          lfsr_d = lfsr_nxt;
          if (!endless_q && prbs_left_q == 16'd1) begin
            prbs_left_d = 16'd0;
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            done_d      = 1'b1;
          end else begin
            out_data_d = lfsr_nxt[DATA_W-1:0];
            if (!endless_q) prbs_left_d = prbs_left_q - 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort has priority over everything, including a start in the same cycle.
    if (stop) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      in_pre_d    = 1'b0;
      done_d      = 1'b0;
      rep_left_d  = '0;
      word_left_d = '0;
      prbs_left_d = '0;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      lfsr_q      <= '0;
      taps_q      <= '0;
      pre_q       <= '0;
      rep_left_q  <= '0;
      word_left_q <= '0;
      prbs_left_q <= '0;
      endless_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_pre_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      taps_q      <= taps_d;
      pre_q       <= pre_d;
      rep_left_q  <= rep_left_d;
      word_left_q <= word_left_d;
      prbs_left_q <= prbs_left_d;
      endless_q   <= endless_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_pre_q    <= in_pre_d;
      done_q      <= done_d;
    end
  end

`ifdef PRBS_GEN_ERR_INJECT_EN
  logic inj_pend_q, inj_pend_d;

  // Hold a pending error until a PRBS word is accepted.
  // A new pulse that lands on a transfer edge applies to the following word.
  always_comb begin
    inj_pend_d = inj_pend_q;
    if (xfer && state_q == S_PRBS) inj_pend_d = 1'b0;
    if (state_d == S_IDLE)         inj_pend_d = 1'b0;
    if (inj_err)                   inj_pend_d = 1'b1;
  end

  // Pending-error flag.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) inj_pend_q <= 1'b0;
    else       inj_pend_q <= inj_pend_d;
  end

  assign out_data = out_data_q ^ DATA_W'(inj_pend_q && state_q == S_PRBS);
`else
  assign out_data = out_data_q;
`endif

  assign out_valid   = out_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign in_preamble = in_pre_q;
  assign done        = done_q;

endmodule

// File: tb/tb_prbs_gen.sv
// Scoreboard bench for prbs_gen.
// The stimulus side pushes the expected word stream of each run into a queue.
// The monitor pops from that queue and compares on every accepted word.
// Expected PRBS words come from a bit-stream recurrence.
// Each new bit is the XOR of earlier bits selected by the tap mask.
// Each word is the last DATA_W bits of that stream, newest bit in bit 0.
module tb_prbs_gen;
  localparam int DW = 8;
  localparam int LW = 16;
  localparam int PW = 32;
  localparam int NW = PW / DW;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          p;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [7:0]    n_rep = '0;
  logic [15:0]   prbs_len = '0;
  logic [PW-1:0] preamble = '0;
  logic [LW-1:0] seed = '0;
  logic [LW-1:0] taps = '0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_valid, busy, in_preamble, done;
`ifdef PRBS_GEN_ERR_INJECT_EN
  logic          inj_err = 1'b0;
`endif

  int   n_chk = 0;
  int   n_fail = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;
  bit   rand_ready = 1'b0;
  bit   stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  exp_t sb_q[$];

  prbs_gen #(.DATA_W(DW), .LFSR_W(LW), .PREAMBLE_W(PW)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .stop(stop), .n_rep(n_rep),
    .prbs_len(prbs_len), .preamble(preamble), .seed(seed), .taps(taps),
`ifdef PRBS_GEN_ERR_INJECT_EN
    .inj_err(inj_err),
`endif
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .in_preamble(in_preamble), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream for one run: preamble words, then nwords PRBS words.
  task automatic push_run(input int nrep, input int nwords, input logic [PW-1:0] pre,
                          input logic [LW-1:0] sd, input logic [LW-1:0] tp);
    bit s[$];
    logic [LW-1:0] st;
    logic [DW-1:0] w;
    exp_t e;
    for (int r = 0; r < nrep; r++)
      for (int k = 0; k < NW; k++) begin
        e.d = DW'(pre >> ((NW - 1 - k) * DW));
        e.p = 1'b1;
        sb_q.push_back(e);
      end
    st = (sd == '0) ? LW'(1) : sd;
    for (int i = LW - 1; i >= 0; i--) s.push_back(st[i]);
    for (int k = 0; k < nwords; k++) begin
      for (int j = 0; j < DW; j++) w[j] = s[s.size() - 1 - j];
      e.d = w;
      e.p = 1'b0;
      sb_q.push_back(e);
      for (int b = 0; b < DW; b++) begin
        bit f;
        f = 1'b0;
        for (int i = 0; i < LW; i++)
          if (tp[i]) f = f ^ s[s.size() - 1 - i];
        s.push_back(f);
      end
    end
  endtask

  // Random or constant downstream accept, changed just after each rising edge.
  initial forever begin
    @(posedge CLK);
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor: pops the scoreboard on each transfer and checks stall and done behaviour.
  always @(negedge CLK) begin
    if (RSTn) begin
      if (stall_prev) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_data_hold", out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h expected no word at %0t", out_data, $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("word_data", out_data, e.d);
          check("word_in_preamble", in_preamble, e.p);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_valid_low", out_valid, 0);
        check("done_sb_empty", sb_q.size(), 0);
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic wait_done(input int dc0, input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (done_cnt != dc0) break;
    end
    if (i == 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done within 3000 cycles", name);
    end
  endtask

  task automatic wait_xfers(input int target, input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (xfer_cnt >= target) break;
    end
    if (i == 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d transfers expected %0d", name, xfer_cnt, target);
    end
  endtask

  // One complete run, with inputs scrambled after capture and a start pulse mid-run.
  task automatic do_run(input logic [7:0] nr, input logic [15:0] pl, input logic [PW-1:0] pre,
                        input logic [LW-1:0] sd, input logic [LW-1:0] tp, input bit rr,
                        input string name);
    int dc0;
    int i;
    push_run(nr, pl, pre, sd, tp);
    rand_ready = rr;
    dc0 = done_cnt;
    @(posedge CLK);
    #1;
    n_rep = nr; prbs_len = pl; preamble = pre; seed = sd; taps = tp; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    n_rep = 8'($urandom); prbs_len = 16'($urandom); preamble = $urandom;
    seed = 16'($urandom); taps = 16'($urandom);
    check({name, "_valid_after_start"}, out_valid, 1);
    check({name, "_busy_after_start"}, busy, 1);
    check({name, "_first_in_preamble"}, in_preamble, (nr != 0));
    for (i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (done_cnt != dc0) break;
      if (i == 4 && busy) start = 1'b1;
      if (i == 5) start = 1'b0;
    end
    start = 1'b0;
    if (i == 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done within 3000 cycles", name);
    end
    repeat (3) @(negedge CLK);
    check({name, "_done_pulses"}, done_cnt - dc0, 1);
    check({name, "_idle_after"}, busy, 0);
    check({name, "_valid_after"}, out_valid, 0);
    rand_ready = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    int x0, dc0;
    #12;
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_preamble", in_preamble, 0);
    check("rst_done", done, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    do_run(8'd2, 16'd3, 32'hDEADBEEF, 16'hACE1, 16'hC000, 1'b0, "basic");
    do_run(8'd0, 16'd4, 32'h12345678, 16'h0000, 16'hB400, 1'b0, "zero_seed");
    do_run(8'd2, 16'd3, 32'hDEADBEEF, 16'hACE1, 16'hC000, 1'b1, "stall");

    // Endless run, then stop and start together after 10 transfers.
    push_run(0, 40, '0, 16'h1D2C, 16'hD008);
    x0 = xfer_cnt;
    dc0 = done_cnt;
    @(posedge CLK);
    #1;
    n_rep = 8'd0; prbs_len = 16'd0; seed = 16'h1D2C; taps = 16'hD008; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_xfers(x0 + 10, "endless");
    @(posedge CLK);
    #1;
    stop = 1'b1; start = 1'b1;
    @(posedge CLK);
    #1;
    stop = 1'b0; start = 1'b0;
    check("stop_valid_low", out_valid, 0);
    check("stop_busy_low", busy, 0);
    repeat (3) @(negedge CLK);
    check("stop_start_ignored", busy, 0);
    check("stop_no_done", done_cnt - dc0, 0);
    sb_q.delete();

    // Asynchronous reset in the middle of the preamble.
    push_run(2, 3, 32'hDEADBEEF, 16'hACE1, 16'hC000);
    x0 = xfer_cnt;
    @(posedge CLK);
    #1;
    n_rep = 8'd2; prbs_len = 16'd3; preamble = 32'hDEADBEEF; seed = 16'hACE1;
    taps = 16'hC000; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_xfers(x0 + 3, "pre_reset");
    #2;
    RSTn = 1'b0;
    #1;
    check("arst_out_data", out_data, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in_preamble", in_preamble, 0);
    check("arst_done", done, 0);
    sb_q.delete();
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    repeat (3) @(negedge CLK);
    check("post_rst_idle", busy, 0);
    check("post_rst_valid", out_valid, 0);
    do_run(8'd2, 16'd3, 32'hDEADBEEF, 16'hACE1, 16'hC000, 1'b0, "restart");

    for (int r = 0; r < 6; r++) begin
      logic [LW-1:0] sd;
      sd = (r == 2) ? '0 : 16'($urandom);
      do_run(8'($urandom_range(0, 3)), 16'($urandom_range(1, 12)), $urandom, sd,
             16'($urandom) | 16'h8000, 1'b1, "random");
    end

`ifdef PRBS_GEN_ERR_INJECT_EN
    push_run(2, 3, 32'hDEADBEEF, 16'hACE1, 16'hC000);
    sb_q[9].d = sb_q[9].d ^ 8'h01;
    dc0 = done_cnt;
    @(posedge CLK);
    #1;
    n_rep = 8'd2; prbs_len = 16'd3; preamble = 32'hDEADBEEF; seed = 16'hACE1;
    taps = 16'hC000; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (out_valid && !in_preamble) break;
    end
    inj_err = 1'b1;
    @(posedge CLK);
    #1;
    inj_err = 1'b0;
    wait_done(dc0, "inject");
    repeat (2) @(negedge CLK);
    sb_q.delete();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected end before 2000000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
